// File: rtl/fdiv_share_ctrl.sv
// rtl/fdiv_share_ctrl.sv - round-robin sharing controller for one multi-cycle fp32 divider
module fdiv_share_ctrl #(
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_overflow,
  output logic        rsp_underflow,
  output logic        rsp_dbz,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_start,
  input  logic [31:0] div_result,
  input  logic        div_overflow,
  input  logic        div_underflow,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LAT - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_rr_last;
  logic              r_gnt_id;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_div_a;
  logic [31:0]       r_div_b;
  logic [31:0]       r_rsp_result;
  logic              r_rsp_ovf;
  logic              r_rsp_unf;
  logic              r_rsp_dbz;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_acc;
  logic              w_rsp_hs;
  logic              w_b_zero;
  logic [31:0]       w_sel_a;
  logic [31:0]       w_sel_b;
  logic [31:0]       w_dbz_result;

  // Tie goes to the requester that was not served last; a lone request always wins.
  assign w_gnt0       = req0_valid & (~req1_valid | r_rr_last);
  assign w_gnt1       = req1_valid & (~req0_valid | ~r_rr_last);
  assign w_acc        = (r_state == S_IDLE) & (w_gnt0 | w_gnt1);
  assign w_sel_a      = w_gnt1 ? req1_a : req0_a;
  assign w_sel_b      = w_gnt1 ? req1_b : req0_b;
  assign w_b_zero     = (w_sel_b[30:0] == 31'd0);
  // 0/0 is a quiet NaN; x/0 is a signed infinity.
  assign w_dbz_result = (w_sel_a[30:0] == 31'd0) ? 32'h7FC00000
                                                 : {w_sel_a[31] ^ w_sel_b[31], 8'hFF, 23'd0};
  // Only the owner's ready completes a response; the other requester's ready is ignored.
  assign w_rsp_hs     = (r_state == S_RESP) & (r_gnt_id ? rsp1_ready : rsp0_ready);

  assign div_a         = r_div_a;
  assign div_b         = r_div_b;
  assign rsp_result    = r_rsp_result;
  assign rsp_overflow  = r_rsp_ovf;
  assign rsp_underflow = r_rsp_unf;
  assign rsp_dbz       = r_rsp_dbz;

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next     = r_state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    div_start  = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        req0_ready = w_gnt0;
        req1_ready = w_gnt1;
        if (w_acc) begin
          w_next = w_b_zero ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        div_start = 1'b1;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        rsp0_valid = ~r_gnt_id;
        rsp1_valid = r_gnt_id;
        if (w_rsp_hs) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latch, latency counter, response capture and round-robin history.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rr_last    <= 1'b1;
      r_gnt_id     <= 1'b0;
      r_cnt        <= '0;
      r_div_a      <= 32'd0;
      r_div_b      <= 32'd0;
      r_rsp_result <= 32'd0;
      r_rsp_ovf    <= 1'b0;
      r_rsp_unf    <= 1'b0;
      r_rsp_dbz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_div_a  <= w_sel_a;
            r_div_b  <= w_sel_b;
            r_gnt_id <= w_gnt1;
            if (w_b_zero) begin
              r_rsp_result <= w_dbz_result;
              r_rsp_ovf    <= 1'b0;
              r_rsp_unf    <= 1'b0;
              r_rsp_dbz    <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          r_cnt <= CNT_LOAD;
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_result <= div_result;
            r_rsp_ovf    <= div_overflow;
            r_rsp_unf    <= div_underflow;
            r_rsp_dbz    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_rr_last <= r_gnt_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_share_ctrl.sv
// tb/tb_fdiv_share_ctrl.sv - self-checking bench for fdiv_share_ctrl with a timestamp-based reference
module tb_fdiv_share_ctrl;

  localparam int DIV_LAT = 4;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_overflow, rsp_underflow, rsp_dbz;
  logic [31:0] div_a, div_b;
  logic        div_start;
  logic [31:0] div_result;
  logic        div_overflow, div_underflow;
  logic        busy;

  int c = 0;
  int n_cmp = 0;
  int n_err = 0;

  fdiv_share_ctrl #(.DIV_LAT(DIV_LAT), .CNT_W(8)) dut (
    .clk(clk), .n_rst(n_rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .rsp_underflow(rsp_underflow), .rsp_dbz(rsp_dbz),
    .div_a(div_a), .div_b(div_b), .div_start(div_start),
    .div_result(div_result), .div_overflow(div_overflow), .div_underflow(div_underflow),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) c <= c + 1;

  // Stand-in divider: sign xor, exponent difference with overflow/underflow, mantissa xor.
  function automatic logic [33:0] div_f(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e;
    logic s;
    logic [7:0] e8;
    ea = a[30:23];
    eb = b[30:23];
    e  = ea - eb + 127;
    s  = a[31] ^ b[31];
    if (e > 254) return {1'b1, 1'b0, s, 8'hFF, 23'd0};
    if (e < 1)   return {1'b0, 1'b1, s, 31'd0};
    e8 = e[7:0];
    return {2'b00, s, e8, a[22:0] ^ b[22:0]};
  endfunction

  function automatic logic [31:0] dbz_res(input logic [31:0] a, input logic [31:0] b);
    if (a[30:0] == 31'd0) return 32'h7FC00000;
    return {a[31] ^ b[31], 8'hFF, 23'd0};
  endfunction

  // Divider model: result valid only in the cycle exactly DIV_LAT after div_start.
  int          st_cyc = -100;
  logic [31:0] d_a = 32'd0, d_b = 32'd0;
  logic [33:0] d_out;
  always @(posedge clk) begin
    if (div_start) begin
      st_cyc <= c;
      d_a    <= div_a;
      d_b    <= div_b;
    end
  end
  assign d_out         = div_f(d_a, d_b);
  assign div_result    = (c == st_cyc + DIV_LAT) ? d_out[31:0] : 32'hDEADBEEF;
  assign div_overflow  = (c == st_cyc + DIV_LAT) ? d_out[33] : 1'b1;
  assign div_underflow = (c == st_cyc + DIV_LAT) ? d_out[32] : 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, c);
    end
  endtask

  // Reference: one op at a time, timestamped at acceptance.
  bit          m_idle = 1'b1, m_rr_last = 1'b1, m_id = 1'b0, m_dbz = 1'b0;
  int          m_t = 0, m_trsp = 0;
  logic [31:0] m_a = 32'd0, m_b = 32'd0, m_res = 32'd0;
  bit          m_ovf = 1'b0, m_unf = 1'b0;
  int          m_grants[$];
  int          m_rsp_cnt[2] = '{0, 0};

  // Compare every cycle, then advance the reference.
  always @(negedge clk) begin : model
    bit g0, g1, e_v0, e_v1, e_st;
    logic [33:0] q;
    if (!n_rst) begin
      m_idle = 1'b1; m_rr_last = 1'b1; m_a = 32'd0; m_b = 32'd0;
    end else begin
      g0 = 0; g1 = 0; e_v0 = 0; e_v1 = 0; e_st = 0;
      if (m_idle) begin
        if (req0_valid && req1_valid) begin
          if (m_rr_last) g0 = 1; else g1 = 1;
        end else begin
          g0 = req0_valid; g1 = req1_valid;
        end
      end else begin
        e_st = !m_dbz && (c == m_t + 1);
        e_v0 = (c >= m_trsp) && !m_id;
        e_v1 = (c >= m_trsp) && m_id;
      end
      chk("req0_ready", req0_ready, g0);
      chk("req1_ready", req1_ready, g1);
      chk("busy", busy, !m_idle);
      chk("div_start", div_start, e_st);
      chk("rsp0_valid", rsp0_valid, e_v0);
      chk("rsp1_valid", rsp1_valid, e_v1);
      chk("div_a", div_a, m_a);
      chk("div_b", div_b, m_b);
      if (e_v0 || e_v1) begin
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_overflow", rsp_overflow, m_ovf);
        chk("rsp_underflow", rsp_underflow, m_unf);
        chk("rsp_dbz", rsp_dbz, m_dbz);
      end
      if (m_idle) begin
        if (g0 || g1) begin
          m_idle = 0;
          m_id   = g1;
          m_a    = g1 ? req1_a : req0_a;
          m_b    = g1 ? req1_b : req0_b;
          m_t    = c;
          m_dbz  = (m_b[30:0] == 31'd0);
          if (m_dbz) begin
            m_res = dbz_res(m_a, m_b); m_ovf = 0; m_unf = 0;
            m_trsp = c + 1;
          end else begin
            q = div_f(m_a, m_b);
            m_res = q[31:0]; m_ovf = q[33]; m_unf = q[32];
            m_trsp = c + DIV_LAT + 2;
          end
          m_grants.push_back(int'(g1));
        end
      end else if (c >= m_trsp && (m_id ? rsp1_ready : rsp0_ready)) begin
        m_idle    = 1;
        m_rr_last = m_id;
        m_rsp_cnt[m_id]++;
      end
    end
  end

  task automatic send(input int id, input logic [31:0] a, input logic [31:0] b, output int t);
    int  n;
    bit  got;
    if (id == 0) begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
    else         begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
    got = 0; n = 0; t = 0;
    while (!got && n < 300) begin
      @(negedge clk);
      if ((id == 0) ? req0_ready : req1_ready) begin
        got = 1; t = c;
      end else begin
        n++;
        @(posedge clk); #1;
      end
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: requester %0d never granted (cycle %0d)", id, c);
      t = c;
    end
    @(posedge clk); #1;
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic at_cycle(input int t);
    do @(negedge clk); while (c < t);
    #1;
    if (c != t) begin
      n_cmp++; n_err++;
      $display("FAIL at_cycle: got %0d expected %0d", c, t);
    end
  endtask

  task automatic drain();
    repeat (DIV_LAT + 10) @(posedge clk);
    #1;
  endtask

  logic [31:0] c0a[3] = '{32'h40000000, 32'h40400000, 32'hC0800000};
  logic [31:0] c0b[3] = '{32'h3F800000, 32'h40000000, 32'h40000000};
  logic [31:0] c1a[3] = '{32'h41200000, 32'h3F800000, 32'h42C80000};
  logic [31:0] c1b[3] = '{32'h40A00000, 32'hC0000000, 32'h41200000};

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t, t2;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_div_start", div_start, 1'b0);
    chk("rst_div_a", div_a, 32'd0);
    chk("rst_div_b", div_b, 32'd0);
    chk("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_flags", {rsp_overflow, rsp_underflow, rsp_dbz}, 3'b000);
    n_rst = 1'b1;

    // Contention: both requesters valid from reset, three ops each.
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    fork
      begin
        int tt;
        for (int k = 0; k < 3; k++) send(0, c0a[k], c0b[k], tt);
      end
      begin
        int tt;
        for (int k = 0; k < 3; k++) send(1, c1a[k], c1b[k], tt);
      end
    join
    drain();
    chk("grant_count", m_grants.size(), 6);
    for (int k = 0; k < m_grants.size() && k < 6; k++) chk("grant_order", m_grants[k], k % 2);
    chk("rsp0_count", m_rsp_cnt[0], 3);
    chk("rsp1_count", m_rsp_cnt[1], 3);

    // Single op with literal timing and quotient.
    send(0, 32'h410C0000, 32'h4086B852, t);
    at_cycle(t + 1);
    chk("single_start", div_start, 1'b1);
    chk("single_div_a", div_a, 32'h410C0000);
    chk("single_div_b", div_b, 32'h4086B852);
    at_cycle(t + 5);
    chk("single_early_valid", rsp0_valid, 1'b0);
    at_cycle(t + 6);
    chk("single_valid", rsp0_valid, 1'b1);
    chk("single_result", rsp_result, 32'h400AB852);
    chk("single_flags", {rsp_overflow, rsp_underflow, rsp_dbz}, 3'b000);
    chk("single_rsp1", rsp1_valid, 1'b0);
    drain();

    // Divide by zero: signed infinity, then NaN, both one cycle after acceptance.
    send(0, 32'h3F800000, 32'h80000000, t);
    at_cycle(t + 1);
    chk("dbz_inf_valid", rsp0_valid, 1'b1);
    chk("dbz_inf_result", rsp_result, 32'hFF800000);
    chk("dbz_inf_flag", rsp_dbz, 1'b1);
    chk("dbz_inf_nostart", div_start, 1'b0);
    drain();
    send(1, 32'h00000000, 32'h00000000, t);
    at_cycle(t + 1);
    chk("dbz_nan_valid", rsp1_valid, 1'b1);
    chk("dbz_nan_result", rsp_result, 32'h7FC00000);
    chk("dbz_nan_flag", rsp_dbz, 1'b1);
    drain();

    // Backpressure on rsp0 while requester 1 waits.
    rsp0_ready = 1'b0;
    send(0, 32'h40400000, 32'h3F800000, t);
    req1_a = 32'h40000000; req1_b = 32'h40000000; req1_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      at_cycle(t + 6 + k);
      chk("bp_rsp0_valid", rsp0_valid, 1'b1);
      chk("bp_result", rsp_result, 32'h40400000);
      chk("bp_req1_ready", req1_ready, 1'b0);
      chk("bp_busy", busy, 1'b1);
    end
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    at_cycle(t + 16);
    chk("bp_release_req1_ready", req1_ready, 1'b0);
    at_cycle(t + 17);
    chk("bp_idle_req1_ready", req1_ready, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    drain();

    // Overflow flag pass-through.
    send(0, 32'h7F000000, 32'h00800000, t);
    at_cycle(t + 6);
    chk("ovf_valid", rsp0_valid, 1'b1);
    chk("ovf_result", rsp_result, 32'h7F800000);
    chk("ovf_flags", {rsp_overflow, rsp_underflow, rsp_dbz}, 3'b100);
    drain();

    // Reset during WAIT aborts the operation.
    send(0, 32'h41200000, 32'h40A00000, t);
    at_cycle(t + 3);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_div_a", div_a, 32'd0);
    chk("mid_rst_div_b", div_b, 32'd0);
    chk("mid_rst_rsp0", rsp0_valid, 1'b0);
    chk("mid_rst_result", rsp_result, 32'd0);
    chk("mid_rst_start", div_start, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      chk("post_rst_rsp0", rsp0_valid, 1'b0);
    end
    @(posedge clk); #1;
    send(0, 32'h41200000, 32'h40A00000, t2);
    at_cycle(t2 + 6);
    chk("post_rst_valid", rsp0_valid, 1'b1);
    chk("post_rst_result", rsp_result, 32'h40000000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fdiv_share_ctrl.md
Name: fdiv_share_ctrl

Overview:
Sequencing controller and round-robin arbiter that shares one multi-cycle IEEE-754 single-precision divider between two requesters. It accepts operand pairs over valid/ready handshakes and launches the divider with a one-cycle start pulse. It waits a fixed divider latency, then returns quotient plus overflow/underflow flags to the requester that issued the operation. Divide-by-zero is resolved locally without occupying the divider. The block sits between client datapaths and the shared divider core.

Parameters:
DIV_LAT, 32, divider cycles from div_start to a valid div_result/flags; legal range 1..255.
CNT_W, 8, width of the latency down-counter; must hold DIV_LAT-1.

Ports:
clk  in  1  system clock; all state on rising edge
n_rst  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operand pair
req0_ready  out  1  requester 0 operands accepted this cycle
req0_a  in  32  requester 0 dividend (IEEE-754 single)
req0_b  in  32  requester 0 divisor
req1_valid  in  1  requester 1 has an operand pair
req1_ready  out  1  requester 1 operands accepted this cycle
req1_a  in  32  requester 1 dividend
req1_b  in  32  requester 1 divisor
rsp0_valid  out  1  response pending for requester 0
rsp0_ready  in  1  requester 0 takes response
rsp1_valid  out  1  response pending for requester 1
rsp1_ready  in  1  requester 1 takes response
rsp_result  out  32  quotient (shared bus, qualified by rspN_valid)
rsp_overflow  out  1  overflow flag of the response
rsp_underflow  out  1  underflow flag of the response
rsp_dbz  out  1  divide-by-zero flag of the response
div_a  out  32  registered dividend to divider
div_b  out  32  registered divisor to divider
div_start  out  1  one-cycle launch pulse
div_result  in  32  divider quotient
div_overflow  in  1  divider overflow
div_underflow  in  1  divider underflow
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE, rr_last=1 (req0 wins first tie), counter=0; all outputs 0, including div_a/div_b and rsp_* registers.
- Reset asserted mid-operation aborts the operation immediately. No response is produced, and the divider result is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant selection: if only one valid is high, grant it. If both are high, grant the requester that was not rr_last.
  - reqN_ready is combinational, high only for the granted requester and only in IDLE.
  - Handshake (valid & ready) latches a/b into div_a/div_b and the grant id.
  - If b[30:0]==0, go to RESP with no div_start and rsp_dbz=1, overflow=0, underflow=0. rsp_result is 32'h7FC00000 when a[30:0]==0; otherwise {a[31]^b[31], 8'hFF, 23'h0}.
  - Otherwise go to ISSUE.
- ISSUE: div_start=1 for exactly this cycle; counter loads DIV_LAT-1; go to WAIT.
- WAIT:
  - If counter==0, capture div_result/div_overflow/div_underflow into rsp_* with rsp_dbz=0, and go to RESP.
  - Otherwise decrement the counter.
  - WAIT lasts exactly DIV_LAT cycles.
- RESP:
  - rspN_valid is high for the granted id only. rsp_* stay stable until rspN_ready.
  - On handshake: rr_last = grant id, go to IDLE. No new request is accepted in that same cycle.
  - The other requester's rsp_ready is ignored.
- Latency for the normal path (handshake in cycle T): div_start in T+1, rsp_valid from T+DIV_LAT+2. Divide-by-zero path: rsp_valid in T+1.
- div_a/div_b hold constant from latch until the next accepted request.
- Requesters may drop valid before ready. No state change results, and arbitration re-evaluates each IDLE cycle.
- Only one operation is in flight; no queuing.

Test Plan:
- Single op, DIV_LAT=4, divider model: req0 a=410C0000 b=4086B852 → div_start one cycle at T+1, div_a/div_b equal the operands; rsp0_valid at T+6 with rsp_result = model quotient and flags; rsp1_valid stays 0.
- Contention: req0 and req1 both valid from reset, each sending 3 ops, rsp always ready → grant order 0,1,0,1,0,1; every response reaches the issuing id.
- Divide-by-zero cases, with no div_start pulse and rsp in T+1:
  - a=3F800000 b=80000000 → rsp_result FF800000, dbz=1.
  - a=00000000 b=00000000 → 7FC00000, dbz=1.
- Backpressure: hold rsp0_ready=0 for 10 cycles while req1_valid=1 → rsp0 outputs stable, req1_ready stays 0, busy=1; release → req1 granted in the first IDLE cycle after return.
- Flag pass-through: model drives div_overflow=1 (a=7F000000 b=00800000) → rsp_overflow=1, underflow=0, dbz=0.
- Reset mid-WAIT: pull n_rst low during WAIT → all outputs 0 immediately; after release no rsp_valid appears, and the next req0 completes normally.
